// File: rtl/interval_timer.sv
// ----------------------------------------------------------------------------
// interval_timer
//
// Reader/consumer side of the interval-parameter store. A start request
// latches an interval selector onto the store address. The timer then waits
// out the store's one-cycle registered read and captures the returned
// duration. It counts that duration down on 1 Hz ticks and pulses `expired`
// to the traffic FSM when the count reaches zero.
//
// Store handshake: the store has no valid/ready pair. The address is held
// stable while in REQ. The store registers its output on every edge where
// prg_sync_in is low and freezes it while prg_sync_in is high. The timer
// therefore leaves REQ only on an edge with prg_sync_in low. It samples
// time_value two edges later, in LOAD.
//
// Ports:
//   clk              in   system clock, rising edge
//   sys_reset_n      in   asynchronous active-low reset
//   start_timer      in   one-cycle start/restart request
//   interval_sel     in   interval selector, sampled only with start_timer
//   one_hz_enable    in   one-cycle tick, once per second
//   prg_sync_in      in   store reprogram strobe (store output stale while high)
//   time_value       in   registered duration returned by the store
//   interval_address out  address driven to the store
//   busy             out  high whenever the timer is not idle
//   expired          out  one-cycle pulse at the end of an interval
//   remaining        out  seconds left in the current interval
// ----------------------------------------------------------------------------
module interval_timer #(
   parameter int TIME_W = 4,
   parameter int ADDR_W = 2
) (
   input  logic              clk,
   input  logic              sys_reset_n,
   input  logic              start_timer,
   input  logic [ADDR_W-1:0] interval_sel,
   input  logic              one_hz_enable,
   input  logic              prg_sync_in,
   input  logic [TIME_W-1:0] time_value,
   output logic [ADDR_W-1:0] interval_address,
   output logic              busy,
   output logic              expired,
   output logic [TIME_W-1:0] remaining
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_REQ    = 3'd1,
      S_WAIT   = 3'd2,
      S_LOAD   = 3'd3,
      S_COUNT  = 3'd4,
      S_EXPIRE = 3'd5
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] addr_nxt;
   logic [TIME_W-1:0] rem_nxt;

   always_comb begin
      state_nxt = state;
      addr_nxt  = interval_address;
      rem_nxt   = remaining;
      // A start request wins from every state. It aborts any interval in
      // flight without an expiry pulse, including one whose final tick
      // arrives in the same cycle. remaining is held until the next LOAD.
      if (start_timer) begin
         state_nxt = S_REQ;
         addr_nxt  = interval_sel;
      end else begin
         case (state)
            S_IDLE: state_nxt = S_IDLE;
            S_REQ: begin
               // The store output is frozen during a reprogram, so stay
               // here until it is free to register our address.
               if (!prg_sync_in) state_nxt = S_WAIT;
            end
            S_WAIT: state_nxt = S_LOAD;
            S_LOAD: begin
               rem_nxt   = time_value;
               state_nxt = (time_value == '0) ? S_EXPIRE : S_COUNT;
            end
            S_COUNT: begin
               if (one_hz_enable && (remaining != '0)) begin
                  rem_nxt = remaining - TIME_W'(1);
                  if (remaining == TIME_W'(1)) state_nxt = S_EXPIRE;
               end
            end
            S_EXPIRE: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
         endcase
      end
   end

   // All outputs are registered. busy and expired are decoded from the
   // next state, so they line up with the state register.
   always_ff @(posedge clk or negedge sys_reset_n) begin
      if (!sys_reset_n) begin
         state            <= S_IDLE;
         interval_address <= '0;
         remaining        <= '0;
         busy             <= 1'b0;
         expired          <= 1'b0;
      end else begin
         state            <= state_nxt;
         interval_address <= addr_nxt;
         remaining        <= rem_nxt;
         busy             <= (state_nxt != S_IDLE);
         expired          <= (state_nxt == S_EXPIRE);
      end
   end

endmodule

// File: tb/tb_interval_timer.sv
// ----------------------------------------------------------------------------
// tb_interval_timer
//
// Bench for interval_timer. It includes a small model of the interval store:
// a one-cycle registered read that is frozen while prg_sync_in is high.
// Directed scenarios and a randomized phase drive the DUT. A behavioural
// reference model predicts busy/expired/remaining/address every cycle.
// ----------------------------------------------------------------------------
module tb_interval_timer;
   localparam int TIME_W = 4;
   localparam int ADDR_W = 2;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic              start = 1'b0;
   logic [ADDR_W-1:0] sel   = '0;
   logic              tick  = 1'b0;
   logic              prg   = 1'b0;
   logic [TIME_W-1:0] time_value = '0;
   logic [ADDR_W-1:0] addr;
   logic              busy;
   logic              expired;
   logic [TIME_W-1:0] remaining;

   interval_timer #(.TIME_W(TIME_W), .ADDR_W(ADDR_W)) dut (
      .clk              (clk),
      .sys_reset_n      (rst_n),
      .start_timer      (start),
      .interval_sel     (sel),
      .one_hz_enable    (tick),
      .prg_sync_in      (prg),
      .time_value       (time_value),
      .interval_address (addr),
      .busy             (busy),
      .expired          (expired),
      .remaining        (remaining)
   );

   // ---------------- store model ----------------
   // Entry 3 is the invalid address and always returns 15.
   logic [TIME_W-1:0] store_tab [4];
   always @(posedge clk) if (!prg) time_value <= store_tab[addr];

   // ---------------- reference model ----------------
   // load_in counts the edges left until the duration is captured:
   // 3 = waiting for the store to be free, 2/1 = read in flight, -1 = none.
   int                m_load_in  = -1;
   logic              m_counting = 1'b0;
   logic              m_exp      = 1'b0;
   logic              m_busy     = 1'b0;
   logic [ADDR_W-1:0] m_addr     = '0;
   logic [TIME_W-1:0] m_rem      = '0;
   logic [TIME_W-1:0] m_latched  = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_addr = '0; m_rem = '0; m_exp = 1'b0; m_counting = 1'b0; m_load_in = -1;
      end else if (start) begin
         m_addr = sel; m_load_in = 3; m_counting = 1'b0; m_exp = 1'b0;
      end else if (m_exp) begin
         m_exp = 1'b0;
      end else if (m_load_in == 3) begin
         if (!prg) begin m_latched = store_tab[m_addr]; m_load_in = 2; end
      end else if (m_load_in == 2) begin
         if (!prg) m_latched = store_tab[m_addr];
         m_load_in = 1;
      end else if (m_load_in == 1) begin
         m_rem = m_latched; m_load_in = -1;
         if (m_latched == '0) m_exp = 1'b1; else m_counting = 1'b1;
      end else if (m_counting && tick) begin
         m_rem = m_rem - 1'b1;
         if (m_rem == '0) begin m_counting = 1'b0; m_exp = 1'b1; end
      end
      m_busy = (m_load_in != -1) || m_counting || m_exp;
   end

   // ---------------- scoreboard ----------------
   int checks    = 0;
   int errors    = 0;
   int exp_count = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
      end
   endtask

   // Checks the DUT against a literal and the model against the same literal.
   task automatic pin(input string name, input logic [31:0] dut_v, input logic [31:0] mod_v,
                      input logic [31:0] lit);
      check(name, dut_v, lit);
      check({name, "_model"}, mod_v, lit);
   endtask

   always @(posedge clk) begin
      #2;
      check("cyc_busy", busy, m_busy);
      check("cyc_expired", expired, m_exp);
      check("cyc_remaining", remaining, m_rem);
      check("cyc_addr", addr, m_addr);
      if (expired === 1'b1) exp_count++;
   end

   // ---------------- driver tasks ----------------
   task automatic do_start(input logic [ADDR_W-1:0] s);
      start = 1'b1; sel = s;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic tick_once();
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
   endtask

   task automatic ticks(input int n, input int gap);
      for (int k = 0; k < n; k++) begin
         repeat (gap) @(negedge clk);
         tick_once();
      end
   endtask

   int e0;

   initial begin
      store_tab[0] = 4'd6; store_tab[1] = 4'd3; store_tab[2] = 4'd3; store_tab[3] = 4'd15;
      repeat (3) @(negedge clk);
      pin("rst_busy", busy, m_busy, 0);
      pin("rst_rem", remaining, m_rem, 0);
      pin("rst_addr", addr, m_addr, 0);
      pin("rst_exp", expired, m_exp, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Base interval, tick every 10 cycles.
      do_start(2'b00);
      pin("t1_addr", addr, m_addr, 0);
      pin("t1_busy", busy, m_busy, 1);
      repeat (3) @(negedge clk);
      pin("t1_load", remaining, m_rem, 6);
      e0 = exp_count;
      for (int i = 0; i < 6; i++) begin
         repeat (9) @(negedge clk);
         tick_once();
         if (i < 5) pin("t1_rem", remaining, m_rem, 5 - i);
      end
      pin("t1_exp", expired, m_exp, 1);
      pin("t1_rem0", remaining, m_rem, 0);
      @(negedge clk);
      pin("t1_exp_low", expired, m_exp, 0);
      pin("t1_busy_low", busy, m_busy, 0);
      check("t1_exp_count", exp_count - e0, 1);

      // Reprogram stall: yellow rewritten to 4 while the store is frozen.
      prg = 1'b1;
      do_start(2'b10);
      store_tab[2] = 4'd4;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         pin("t2_stall_busy", busy, m_busy, 1);
         pin("t2_stall_rem", remaining, m_rem, 0);
      end
      prg = 1'b0;
      repeat (2) @(negedge clk);
      pin("t2_preload", remaining, m_rem, 0);
      @(negedge clk);
      pin("t2_load", remaining, m_rem, 4);
      e0 = exp_count;
      ticks(4, 2);
      pin("t2_exp", expired, m_exp, 1);
      @(negedge clk);
      check("t2_exp_count", exp_count - e0, 1);

      // Invalid address returns 15.
      do_start(2'b11);
      repeat (3) @(negedge clk);
      pin("t3_load", remaining, m_rem, 15);
      e0 = exp_count;
      ticks(14, 1);
      pin("t3_rem1", remaining, m_rem, 1);
      pin("t3_no_exp", expired, m_exp, 0);
      ticks(1, 1);
      pin("t3_exp", expired, m_exp, 1);
      @(negedge clk);
      check("t3_exp_count", exp_count - e0, 1);

      // Restart mid-count into extend.
      do_start(2'b00);
      repeat (3) @(negedge clk);
      ticks(3, 2);
      pin("t4_rem3", remaining, m_rem, 3);
      e0 = exp_count;
      do_start(2'b01);
      pin("t4_addr", addr, m_addr, 1);
      repeat (3) @(negedge clk);
      pin("t4_reload", remaining, m_rem, 3);
      check("t4_no_exp", exp_count - e0, 0);
      ticks(3, 2);
      pin("t4_exp", expired, m_exp, 1);
      @(negedge clk);
      check("t4_exp_count", exp_count - e0, 1);

      // Start coincides with the final tick.
      do_start(2'b00);
      repeat (3) @(negedge clk);
      ticks(5, 1);
      pin("t5_rem1", remaining, m_rem, 1);
      e0 = exp_count;
      start = 1'b1; sel = 2'b01; tick = 1'b1;
      @(negedge clk);
      start = 1'b0; tick = 1'b0;
      pin("t5_exp", expired, m_exp, 0);
      pin("t5_busy", busy, m_busy, 1);
      pin("t5_held", remaining, m_rem, 1);
      repeat (3) @(negedge clk);
      pin("t5_load", remaining, m_rem, 3);
      check("t5_no_exp", exp_count - e0, 0);

      // Asynchronous reset mid-count at remaining=2.
      ticks(1, 1);
      pin("t6_rem2", remaining, m_rem, 2);
      e0 = exp_count;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      pin("t6_busy", busy, m_busy, 0);
      pin("t6_rem", remaining, m_rem, 0);
      pin("t6_addr", addr, m_addr, 0);
      pin("t6_exp", expired, m_exp, 0);
      repeat (2) @(negedge clk);
      check("t6_no_exp", exp_count - e0, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Randomized traffic against the model.
      repeat (3000) begin
         @(negedge clk);
         start = ($urandom_range(0, 19) == 0);
         sel   = ADDR_W'($urandom_range(0, 3));
         tick  = ($urandom_range(0, 3) == 0);
         prg   = ($urandom_range(0, 5) == 0);
      end
      @(negedge clk);
      start = 1'b0; tick = 1'b0; prg = 1'b0;
      repeat (5) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/interval_timer.md
Name: interval_timer

Overview:
- Consumer and reader side of the interval-parameter store.
- Takes a start request with an interval selector, drives the store's interval address, and captures the returned 4-bit duration after the store's one-cycle registered read.
- Counts the duration down on 1 Hz enable ticks, then pulses expiry to the traffic FSM.
- Tolerates the store being mid-reprogram: the store freezes its output while prg_sync_in is high.

Parameters:
- TIME_W, 4, width of time_value and remaining.
- ADDR_W, 2, width of interval_sel and interval_address.

Ports:
- clk  in  1  system clock, rising edge
- sys_reset_n  in  1  asynchronous active-low reset
- start_timer  in  1  one-cycle start/restart request
- interval_sel  in  ADDR_W  interval to run: 00 base, 01 extend, 10 yellow, 11 invalid (store returns 15)
- one_hz_enable  in  1  one-cycle tick, once per second
- prg_sync_in  in  1  store reprogram strobe; store output is stale while high
- time_value  in  TIME_W  registered duration returned by the store
- interval_address  out  ADDR_W  address driven to the store
- busy  out  1  high in any state other than IDLE
- expired  out  1  one-cycle pulse at end of interval
- remaining  out  TIME_W  seconds left in the current interval

Behaviour:
- Reset is asynchronous, sys_reset_n low:
  - state=IDLE, interval_address=00, remaining=0, expired=0, busy=0.
  - Mid-operation reset aborts with no expired pulse.
- All outputs are registered. States: IDLE, REQ, WAIT, LOAD, COUNT, EXPIRE.
- IDLE:
  - start_timer at edge N: interval_address<=interval_sel, go REQ.
  - Otherwise hold.
- REQ: the address is stable for the store.
  - prg_sync_in=1: stay in REQ, because the store does not update its output.
  - prg_sync_in=0: go WAIT. The store registers output_value at this edge.
- WAIT: unconditional, go LOAD. Absorbs the store's register stage.
- LOAD: remaining<=time_value.
  - time_value==0: go EXPIRE.
  - Otherwise go COUNT.
- Minimum start-to-load latency with prg_sync_in low: start at edge N, remaining valid after edge N+3.
- COUNT:
  - On one_hz_enable: remaining==1 gives remaining<=0 and go EXPIRE; else remaining<=remaining-1.
  - Without a tick: hold.
  - The first tick may arrive anytime, so a partial first second is accepted.
- EXPIRE:
  - expired=1 for exactly this one cycle.
  - Next state is IDLE, or REQ if start_timer is high.
  - remaining stays 0.
- Restart: start_timer in REQ/WAIT/LOAD/COUNT aborts the current interval.
  - interval_address<=interval_sel, go REQ; remaining is held until the next LOAD.
  - No expired pulse for the aborted interval.
- Simultaneous events in COUNT:
  - start_timer together with the final tick: start wins, expired is not asserted, go REQ.
  - one_hz_enable is ignored outside COUNT.
- interval_sel is sampled only on the start edge; later changes have no effect.
- Decrement is unsigned TIME_W-bit and never wraps. Underflow is unreachable because a 0 load goes straight to EXPIRE.
- prg_sync_in is examined only in REQ. A reprogram during COUNT does not alter the running interval.

Test Plan:
- Reset defaults:
  - Stimulus: store at defaults (base 6); start_timer with sel=00; tick every 10 cycles.
  - Required: interval_address=00 one cycle after start; remaining=6 three cycles after start; expired pulses exactly once, on the cycle after the 6th tick; busy falls the cycle after that.
- Reprogram stall:
  - Stimulus: start sel=10 while prg_sync_in is held high for 5 cycles, during which the store is reprogrammed yellow=4.
  - Required: FSM stays in REQ for all 5 cycles; remaining=4 after the load; 4 ticks later expired pulses.
- Invalid address:
  - Stimulus: start with sel=11.
  - Required: remaining loads 15; expired after 15 ticks.
- Restart:
  - Stimulus: run base=6; after 3 ticks (remaining=3) pulse start sel=01 (extend=3).
  - Required: no expired pulse for the aborted base interval; remaining reloads to 3; expired after 3 further ticks.
- Simultaneous start and final tick:
  - Stimulus: start_timer coincides with the tick that would make remaining 1->0.
  - Required: expired stays 0; FSM goes REQ; new interval loads.
- Async reset mid-COUNT:
  - Stimulus: drop sys_reset_n between clock edges while remaining=2.
  - Required: busy=0, remaining=0, interval_address=00 immediately, without waiting for a clock edge; no expired pulse.
